clk_div_ratio_ctrl: RTL and testbench

//  Sequences ratio changes for the clock divider. Two requesters share the divider's ratio/enable inputs
//  (e.g. CPU config, DFT). Round-robin arbitration; glitch-safe change: gate -> load -> ungate -> lock wait.

---
 rtl/clk_div_ratio_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_clk_div_ratio_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ratio_ctrl.sv
// clk_div_ratio_ctrl
// Arbitrates two ratio requesters (round-robin) and sequences a glitch-safe
// ratio change on the clock divider: gate the divided clock, load the new
// ratio, ungate, then wait one divided period for the divider to settle.
// Only one request is in flight; nothing is queued internally.
module clk_div_ratio_ctrl #(
  parameter int RATIO_WIDTH = 5,
  parameter int RESET_RATIO = 1,
  parameter int GATE_CYCLES = 2
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_req0_valid,
  input  logic [RATIO_WIDTH-1:0] i_req0_ratio,
  output logic                   o_req0_ready,
  input  logic                   i_req1_valid,
  input  logic [RATIO_WIDTH-1:0] i_req1_ratio,
  output logic                   o_req1_ready,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_clk_en,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_done_id
);

  // Lock length is 2*ratio, so it needs one extra bit over the ratio width.
  // The shared counter must also reach GATE_CYCLES-1.
  localparam int LOCK_W = RATIO_WIDTH + 1;
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam int CNT_W  = (LOCK_W > GATE_W) ? LOCK_W : GATE_W;

  localparam logic [CNT_W-1:0]       GATE_LAST  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [RATIO_WIDTH-1:0] RATIO_RST  = RATIO_WIDTH'(RESET_RATIO);
  localparam logic [RATIO_WIDTH-1:0] RATIO_ONE  = RATIO_WIDTH'(1);
  localparam logic [LOCK_W-1:0]      LOCK_ONE   = LOCK_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_LOAD,
    ST_UNGATE,
    ST_LOCK
  } state_t;

  state_t                 state_reg,      state_next;
  logic [RATIO_WIDTH-1:0] div_ratio_reg,  div_ratio_next;
  logic                   clk_en_reg,     clk_en_next;
  logic                   done_reg,       done_next;
  logic                   done_id_reg,    done_id_next;
  logic [CNT_W-1:0]       cnt_reg,        cnt_next;
  logic [RATIO_WIDTH-1:0] req_ratio_reg,  req_ratio_next;
  logic                   req_id_reg,     req_id_next;
  logic                   last_grant_reg, last_grant_next;

  // Requester inputs gathered into indexable form.
  logic [1:0]             req_valid;
  logic [RATIO_WIDTH-1:0] req_ratio [2];
  logic [1:0]             req_ready;

  assign req_valid    = {i_req1_valid, i_req0_valid};
  assign req_ratio[0] = i_req0_ratio;
  assign req_ratio[1] = i_req1_ratio;

  // Round-robin pick: on a tie the requester that did not win last time gets
  // it; otherwise the only valid requester wins.
  logic grant_id;
  logic grant_any;
  logic accept;
  logic [RATIO_WIDTH-1:0] grant_ratio;

  assign grant_any   = |req_valid;
  assign grant_id    = (&req_valid) ? ~last_grant_reg : ~req_valid[0];
  assign accept      = (state_reg == ST_IDLE) && grant_any;
  assign grant_ratio = req_ratio[grant_id];

  // Ready is offered only while idle and only to the granted requester,
  // so both readies can never be high together.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ST_IDLE) && req_valid[gi] &&
                             (grant_id == 1'(gi));
    end
  endgenerate

  assign o_req0_ready = req_ready[0];
  assign o_req1_ready = req_ready[1];

  // Settle time after ungating: one divided period, minimum one cycle.
  logic [LOCK_W-1:0] lock_len;
  logic [LOCK_W-1:0] lock_last;
  logic [CNT_W-1:0]  lock_last_ext;

  assign lock_len      = (req_ratio_reg <= RATIO_ONE) ? LOCK_ONE : {req_ratio_reg, 1'b0};
  assign lock_last     = lock_len - LOCK_ONE;
  assign lock_last_ext = CNT_W'(lock_last);

  // Next-state and next-output logic for the change sequence.
  always_comb begin
    state_next      = state_reg;
    div_ratio_next  = div_ratio_reg;
    clk_en_next     = clk_en_reg;
    done_next       = 1'b0;
    done_id_next    = done_id_reg;
    cnt_next        = cnt_reg;
    req_ratio_next  = req_ratio_reg;
    req_id_next     = req_id_reg;
    last_grant_next = last_grant_reg;

    case (state_reg)
      ST_IDLE: begin
        clk_en_next = i_enable;
        if (accept) begin
          req_ratio_next  = grant_ratio;
          req_id_next     = grant_id;
          last_grant_next = grant_id;
          if (grant_ratio == div_ratio_reg) begin
            // Already at the requested ratio: complete without gating.
            done_next    = 1'b1;
            done_id_next = grant_id;
          end else begin
            clk_en_next = 1'b0;
            cnt_next    = '0;
            state_next  = ST_GATE;
          end
        end
      end

      ST_GATE: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == GATE_LAST) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // The divider sees the new ratio only while its enable is low.
        div_ratio_next = req_ratio_reg;
        state_next     = ST_UNGATE;
      end

      ST_UNGATE: begin
        clk_en_next = i_enable;
        cnt_next    = '0;
        state_next  = ST_LOCK;
      end

      ST_LOCK: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == lock_last_ext) begin
          done_next    = 1'b1;
          done_id_next = req_id_reg;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      div_ratio_reg  <= RATIO_RST;
      clk_en_reg     <= 1'b0;
      done_reg       <= 1'b0;
      done_id_reg    <= 1'b0;
      cnt_reg        <= '0;
      req_ratio_reg  <= '0;
      req_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      div_ratio_reg  <= div_ratio_next;
      clk_en_reg     <= clk_en_next;
      done_reg       <= done_next;
      done_id_reg    <= done_id_next;
      cnt_reg        <= cnt_next;
      req_ratio_reg  <= req_ratio_next;
      req_id_reg     <= req_id_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign o_div_ratio = div_ratio_reg;
  assign o_clk_en    = clk_en_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_done      = done_reg;
  assign o_done_id   = done_id_reg;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Bench for clk_div_ratio_ctrl: directed scenarios with literal expectations,
// then randomized requesters checked every cycle against a timeline model.
module tb_clk_div_ratio_ctrl;

  localparam int RW = 5;
  localparam int G  = 2;

  logic          i_ref_clk = 1'b0;
  logic          i_rst_n   = 1'b0;
  logic          i_enable  = 1'b0;
  logic [1:0]    rq_v      = 2'b00;
  logic [RW-1:0] rq_r [2];
  logic          o_req0_ready, o_req1_ready;
  logic [RW-1:0] o_div_ratio;
  logic          o_clk_en, o_busy, o_done, o_done_id;

  clk_div_ratio_ctrl #(.RATIO_WIDTH(RW), .RESET_RATIO(1), .GATE_CYCLES(G)) dut (
    .i_ref_clk    (i_ref_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_req0_valid (rq_v[0]),
    .i_req0_ratio (rq_r[0]),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (rq_v[1]),
    .i_req1_ratio (rq_r[1]),
    .o_req1_ready (o_req1_ready),
    .o_div_ratio  (o_div_ratio),
    .o_clk_en     (o_clk_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_done_id    (o_done_id)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: expected outputs after the latest edge, plus the timeline of the
  // request in flight expressed as absolute edge numbers.
  int m_cyc = 0;
  int m_ratio, m_clk_en, m_done, m_done_id, m_last, m_busy;
  int t_ld, t_ung, t_done, f_ratio, f_id;
  int acc_id = -1;
  int n_txn  = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lock_len(input int r);
    return (r <= 1) ? 1 : 2 * r;
  endfunction

  function automatic int grant_of(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    int g;
    if (m_busy != 0) return 2'b00;
    g = grant_of(rq_v[0], rq_v[1], m_last);
    if (g == 0) return 2'b01;
    if (g == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ratio = 1; m_clk_en = 0; m_done = 0; m_done_id = 0;
    m_last = 1; m_busy = 0; acc_id = -1;
  endtask

  task automatic model_step();
    int g, r;
    m_cyc++;
    m_done = 0;
    acc_id = -1;
    if (m_busy != 0) begin
      if (m_cyc == t_ld)  m_ratio  = f_ratio;
      if (m_cyc == t_ung) m_clk_en = int'(i_enable);
      if (m_cyc == t_done) begin
        m_done = 1; m_done_id = f_id; m_busy = 0;
      end
    end else begin
      g = grant_of(rq_v[0], rq_v[1], m_last);
      m_clk_en = int'(i_enable);
      if (g >= 0) begin
        acc_id = g;
        m_last = g;
        r = int'(rq_r[g]);
        n_txn++;
        if (r == m_ratio) begin
          m_done = 1; m_done_id = g;
          $display("txn %0d edge %0d: req%0d ratio %0d same ratio, immediate done", n_txn, m_cyc, g, r);
        end else begin
          m_busy = 1; m_clk_en = 0; f_ratio = r; f_id = g;
          t_ld   = m_cyc + G + 1;
          t_ung  = m_cyc + G + 2;
          t_done = t_ung + lock_len(r);
          $display("txn %0d edge %0d: req%0d ratio %0d -> %0d, done expected at edge %0d",
                   n_txn, m_cyc, g, m_ratio, r, t_done);
        end
      end
    end
  endtask

  // One clock edge: advance the model, then leave time for inputs to change.
  task automatic tick();
    @(posedge i_ref_clk);
    if (i_rst_n) model_step();
    #2;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; chk_en = 1'b0; rq_v = 2'b00;
    model_reset();
    repeat (2) tick();
    i_rst_n = 1'b1; chk_en = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (o_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic new_req(input int i);
    int sel;
    sel = $urandom_range(0, 9);
    rq_v[i] = 1'b1;
    if (sel < 2)       rq_r[i] = RW'(m_ratio);
    else if (sel == 2) rq_r[i] = RW'(31);
    else if (sel == 3) rq_r[i] = RW'(0);
    else               rq_r[i] = RW'($urandom_range(1, 6));
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (rq_v[i] && acc_id == i) begin
        rq_v[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) new_req(i);
      end else if (!rq_v[i] && $urandom_range(0, 3) == 0) begin
        new_req(i);
      end
    end
    if ($urandom_range(0, 9) == 0) i_enable = ~i_enable;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge i_ref_clk) begin
    if (chk_en && i_rst_n) begin
      logic [1:0] er;
      er = exp_ready();
      check("div_ratio", 32'(o_div_ratio), m_ratio);
      check("clk_en",    32'(o_clk_en),    m_clk_en);
      check("busy",      32'(o_busy),      m_busy);
      check("done",      32'(o_done),      m_done);
      if (m_done != 0) check("done_id", 32'(o_done_id), m_done_id);
      check("ready0", 32'(o_req0_ready), int'(er[0]));
      check("ready1", 32'(o_req1_ready), int'(er[1]));
    end
  end

  initial begin
    int lat;
    int ids[$];
    rq_r[0] = '0; rq_r[1] = '0;
    model_reset();

    // Reset with enable requested.
    i_enable = 1'b1;
    repeat (3) @(posedge i_ref_clk);
    #2;
    check("rst_ratio",  32'(o_div_ratio), 1);
    check("rst_clk_en", 32'(o_clk_en), 0);
    check("rst_done",   32'(o_done), 0);
    check("rst_busy",   32'(o_busy), 0);
    i_rst_n = 1'b1;
    #1 check("rel_clk_en_before_edge", 32'(o_clk_en), 0);
    chk_en = 1'b1;
    tick();
    check("rel_clk_en_after_edge", 32'(o_clk_en), 1);

    // Ratio 1 -> 4 from requester 0.
    rq_v[0] = 1'b1; rq_r[0] = 5'd4;
    tick();
    rq_v[0] = 1'b0;
    check("r4_e0_clk_en", 32'(o_clk_en), 0);
    check("r4_e0_busy",   32'(o_busy), 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2)  check("r4_e2_ratio", 32'(o_div_ratio), 1);
      if (k == 3)  check("r4_e3_ratio", 32'(o_div_ratio), 4);
      if (k == 3)  check("r4_e3_clk_en", 32'(o_clk_en), 0);
      if (k == 4)  check("r4_e4_clk_en", 32'(o_clk_en), 1);
      if (k == 11) check("r4_e11_done", 32'(o_done), 0);
      if (k == 11) check("r4_e11_busy", 32'(o_busy), 1);
      if (k == 12) check("r4_e12_done", 32'(o_done), 1);
      if (k == 12) check("r4_e12_id",   32'(o_done_id), 0);
      if (k == 12) check("r4_e12_busy", 32'(o_busy), 0);
    end
    tick();
    check("r4_done_cleared", 32'(o_done), 0);

    // Ties from reset alternate 0,1,0,1.
    do_reset();
    rq_v = 2'b11; rq_r[0] = 5'd2; rq_r[1] = 5'd3;
    for (int k = 0; k < 200 && ids.size() < 4; k++) begin
      tick();
      if (o_done) ids.push_back(int'(o_done_id));
    end
    rq_v = 2'b00;
    check("tie_count", 32'(ids.size()), 4);
    for (int i = 0; i < ids.size() && i < 4; i++) check("tie_order", 32'(ids[i]), i % 2);

    // Same ratio from requester 1: no gating, done on the accept edge.
    do_reset();
    rq_v[1] = 1'b1; rq_r[1] = 5'd1;
    tick();
    rq_v[1] = 1'b0;
    check("same_done",   32'(o_done), 1);
    check("same_id",     32'(o_done_id), 1);
    check("same_clk_en", 32'(o_clk_en), 1);
    check("same_busy",   32'(o_busy), 0);
    repeat (3) begin
      tick();
      check("same_clk_en_hold", 32'(o_clk_en), 1);
    end

    // Max ratio 31, then ratio 0.
    rq_v[0] = 1'b1; rq_r[0] = 5'd31;
    tick();
    rq_v[0] = 1'b0;
    wait_done(100, lat);
    check("max_latency", 32'(lat), 66);
    check("max_ratio",   32'(o_div_ratio), 31);
    rq_v[1] = 1'b1; rq_r[1] = 5'd0;
    tick();
    rq_v[1] = 1'b0;
    wait_done(20, lat);
    check("zero_latency", 32'(lat), 5);
    check("zero_ratio",   32'(o_div_ratio), 0);

    // Reset during LOCK; the still-held request is accepted again afterwards.
    rq_v[0] = 1'b1; rq_r[0] = 5'd8;
    tick();
    repeat (8) tick();
    check("lock_busy", 32'(o_busy), 1);
    i_rst_n = 1'b0; chk_en = 1'b0;
    model_reset();
    #1;
    check("midrst_ratio",  32'(o_div_ratio), 1);
    check("midrst_clk_en", 32'(o_clk_en), 0);
    check("midrst_busy",   32'(o_busy), 0);
    check("midrst_done",   32'(o_done), 0);
    repeat (2) begin
      tick();
      check("midrst_no_done", 32'(o_done), 0);
    end
    i_rst_n = 1'b1; chk_en = 1'b1;
    tick();
    rq_v[0] = 1'b0;
    check("reacc_busy",   32'(o_busy), 1);
    check("reacc_clk_en", 32'(o_clk_en), 0);
    wait_done(40, lat);
    check("reacc_latency", 32'(lat), 20);
    check("reacc_id",      32'(o_done_id), 0);

    // Randomized requesters and enable.
    repeat (3000) begin
      tick();
      drive_random();
    end
    rq_v = 2'b00;
    repeat (80) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
